l2req_rr_arbiter: RTL and testbench

// Round-robin arbiter that shares the single per-core L2 request port between the L1

---
 rtl/l2req_rr_arbiter_if.sv | 36 +++
 rtl/l2req_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_l2req_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2req_rr_arbiter_if.sv
// L2 request port bundle: per-requester valid/ready/packet inputs and the single
// registered request stream presented to L2.
interface l2req_rr_arbiter_if #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned UNIT_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PACKET_WIDTH-1:0] req_packet;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            l2req_valid;
    logic [PACKET_WIDTH-1:0]         l2req_packet;
    logic [UNIT_WIDTH-1:0]           l2req_unit;
    logic                            l2req_ready;

    // The arbiter masters the L2 request port and sinks the requester handshakes.
    modport master (
        input  req_valid,
        input  req_packet,
        output req_ready,
        output l2req_valid,
        output l2req_packet,
        output l2req_unit,
        input  l2req_ready
    );

    modport slave (
        output req_valid,
        output req_packet,
        input  req_ready,
        input  l2req_valid,
        input  l2req_packet,
        input  l2req_unit,
        output l2req_ready
    );
endinterface

// File: rtl/l2req_rr_arbiter.sv
// Round-robin arbiter sharing the per-core L2 request port between icache, dcache and
// store buffer, with a registered output stage and stall/starvation perf events.
module l2req_rr_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    l2req_rr_arbiter_if.master bus,
    output logic               pc_event_l2_stall,
    output logic [NUM_REQ-1:0] pc_event_starved
);
    localparam int unsigned UnitWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntWidth  = $clog2(STARVE_LIMIT + 1);
    localparam logic [UnitWidth-1:0] LastId = UnitWidth'(NUM_REQ - 1);
    localparam logic [CntWidth-1:0]  CntMax = CntWidth'(STARVE_LIMIT);

    logic                    l2req_valid_q;
    logic [PACKET_WIDTH-1:0] l2req_packet_q;
    logic [UnitWidth-1:0]    l2req_unit_q;
    logic [UnitWidth-1:0]    rr_ptr_q;
    logic [CntWidth-1:0]     wait_cnt_q [NUM_REQ];
    logic [CntWidth-1:0]     wait_cnt_d [NUM_REQ];

    logic                    load_en;
    logic                    found;
    logic [UnitWidth-1:0]    winner;
    logic [UnitWidth-1:0]    cand;
    logic [UnitWidth-1:0]    next_ptr;
    logic [PACKET_WIDTH-1:0] win_packet;

    function automatic logic [UnitWidth-1:0] wrap_add(input logic [UnitWidth-1:0] base,
                                                      input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return UnitWidth'(sum);
    endfunction

    // Output stage can refill in the same cycle it drains.
    assign load_en = !l2req_valid_q || bus.l2req_ready;

    // Scan IDs starting at rr_ptr; the first valid one wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = wrap_add(rr_ptr_q, off);
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && bus.req_valid[k] && (cand == UnitWidth'(k))) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    always_comb begin
        win_packet = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (winner == UnitWidth'(k)) begin
                win_packet = bus.req_packet[k*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    assign next_ptr = (winner == LastId) ? '0 : winner + UnitWidth'(1);

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            bus.req_ready[k] = load_en && found && (winner == UnitWidth'(k));
        end
    end

    // Wait counters track consecutive cycles a requester is valid but not granted.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!bus.req_valid[k] || bus.req_ready[k]) begin
                wait_cnt_d[k] = '0;
            end else if (wait_cnt_q[k] != CntMax) begin
                wait_cnt_d[k] = wait_cnt_q[k] + CntWidth'(1);
            end else begin
                wait_cnt_d[k] = wait_cnt_q[k];
            end
        end
    end

    always_comb begin
        pc_event_starved = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pc_event_starved[k] = (wait_cnt_q[k] == CntMax);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2req_valid_q  <= 1'b0;
            l2req_packet_q <= '0;
            l2req_unit_q   <= '0;
            rr_ptr_q       <= '0;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                wait_cnt_q[k] <= '0;
            end
        end else begin
            if (load_en) begin
                if (found) begin
                    l2req_valid_q  <= 1'b1;
                    l2req_packet_q <= win_packet;
                    l2req_unit_q   <= winner;
                    rr_ptr_q       <= next_ptr;
                end else begin
                    l2req_valid_q <= 1'b0;
                end
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                wait_cnt_q[k] <= wait_cnt_d[k];
            end
        end
    end

    assign bus.l2req_valid  = l2req_valid_q;
    assign bus.l2req_packet = l2req_packet_q;
    assign bus.l2req_unit   = l2req_unit_q;

    assign pc_event_l2_stall = l2req_valid_q && !bus.l2req_ready;
endmodule

// File: tb/tb_l2req_rr_arbiter.sv
// Bench for l2req_rr_arbiter: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model.
module tb_l2req_rr_arbiter;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned PW      = 128;
    localparam int unsigned LIMIT   = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               pc_event_l2_stall;
    logic [NUM_REQ-1:0] pc_event_starved;

    l2req_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .PACKET_WIDTH(PW)) bus ();

    l2req_rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .PACKET_WIDTH(PW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .pc_event_l2_stall(pc_event_l2_stall),
        .pc_event_starved (pc_event_starved)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] rv;
        logic       l2r;
        logic [2:0] ready;
        logic       valid;
        logic [1:0] unit;
        logic       stall;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] tb_pkt(input int i);
        return PW'(32'hC0DE_0000 + i);
    endfunction

    task automatic set_pkt(input int i, input logic [PW-1:0] p);
        bus.req_packet[i*PW +: PW] = p;
    endtask

    // Apply inputs for this cycle and move to the sampling point (negedge).
    task automatic drive(input logic [2:0] rv, input logic l2r);
        bus.req_valid   = rv;
        bus.l2req_ready = l2r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.req_valid   = '0;
        bus.req_packet  = '0;
        bus.l2req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Reference model state
    bit           m_valid;
    logic [PW-1:0] m_pkt;
    int           m_unit;
    int           m_ptr;
    int           m_cnt [NUM_REQ];
    bit           pend [NUM_REQ];
    logic [PW-1:0] pend_pkt [NUM_REQ];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // {rv, l2r, exp ready, exp l2req_valid, exp unit, exp stall}; starts from reset state
        tbl[0]  = '{3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 1'b0};
        tbl[4]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 1'b0};
        tbl[5]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
        tbl[6]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
        tbl[7]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd1, 1'b0};
        tbl[9]  = '{3'b000, 1'b0, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[10] = '{3'b011, 1'b0, 3'b001, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{3'b010, 1'b1, 3'b010, 1'b1, 2'd0, 1'b0};
        tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd1, 1'b0};
        tbl[13] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 1'b0};

        do_reset();

        // Idle after reset
        drive(3'b000, 1'b0);
        check("reset_valid", PW'(bus.l2req_valid), PW'(0));
        check("reset_ready", PW'(bus.req_ready), PW'(0));
        check("reset_packet", bus.l2req_packet, PW'(0));
        check("reset_starved", PW'(pc_event_starved), PW'(0));
        tick();

        for (int i = 0; i < NUM_REQ; i++) set_pkt(i, tb_pkt(i));
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rv, tbl[i].l2r);
            check($sformatf("tbl%0d_ready", i), PW'(bus.req_ready), PW'(tbl[i].ready));
            check($sformatf("tbl%0d_valid", i), PW'(bus.l2req_valid), PW'(tbl[i].valid));
            check($sformatf("tbl%0d_unit", i), PW'(bus.l2req_unit), PW'(tbl[i].unit));
            check($sformatf("tbl%0d_stall", i), PW'(pc_event_l2_stall), PW'(tbl[i].stall));
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_packet", i), bus.l2req_packet, tb_pkt(int'(tbl[i].unit)));
            end
            tick();
        end

        // Dcache packet 0xA5 stalled by L2 for 5 cycles while icache waits
        set_pkt(1, PW'(8'hA5));
        drive(3'b010, 1'b0);
        check("stall_load_ready", PW'(bus.req_ready), PW'(3'b010));
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(3'b001, 1'b0);
            check($sformatf("stall%0d_flag", c), PW'(pc_event_l2_stall), PW'(1));
            check($sformatf("stall%0d_ready", c), PW'(bus.req_ready), PW'(0));
            check($sformatf("stall%0d_packet", c), bus.l2req_packet, PW'(8'hA5));
            check($sformatf("stall%0d_unit", c), PW'(bus.l2req_unit), PW'(1));
            tick();
        end
        drive(3'b001, 1'b1);
        check("drain_ready", PW'(bus.req_ready), PW'(3'b001));
        check("drain_packet", bus.l2req_packet, PW'(8'hA5));
        check("drain_stall", PW'(pc_event_l2_stall), PW'(0));
        tick();
        drive(3'b000, 1'b1);
        check("drain_next_unit", PW'(bus.l2req_unit), PW'(0));
        check("drain_next_packet", bus.l2req_packet, tb_pkt(0));
        tick();
        drive(3'b000, 1'b0);
        check("drain_idle_valid", PW'(bus.l2req_valid), PW'(0));
        tick();

        // Store buffer starvation behind a stalled icache packet
        drive(3'b001, 1'b0);
        check("starve_load_ready", PW'(bus.req_ready), PW'(3'b001));
        tick();
        for (int j = 1; j <= 20; j++) begin
            drive(3'b100, 1'b0);
            check($sformatf("starve%0d_ready", j), PW'(bus.req_ready), PW'(0));
            // Counter reaches the limit after 15 waiting edges and then saturates.
            check($sformatf("starve%0d_flag", j), PW'(pc_event_starved[2]), PW'(j > 15));
            tick();
        end
        drive(3'b100, 1'b1);
        check("starve_grant_ready", PW'(bus.req_ready), PW'(3'b100));
        check("starve_grant_flag", PW'(pc_event_starved[2]), PW'(1));
        tick();
        drive(3'b000, 1'b1);
        check("starve_clear_flag", PW'(pc_event_starved), PW'(0));
        check("starve_clear_unit", PW'(bus.l2req_unit), PW'(2));
        tick();
        drive(3'b000, 1'b0);
        tick();

        // Asynchronous reset in the middle of a stall
        drive(3'b010, 1'b0);
        tick();
        drive(3'b000, 1'b0);
        check("areset_pre_valid", PW'(bus.l2req_valid), PW'(1));
        #2 reset = 1'b1;
        #1;
        check("areset_valid", PW'(bus.l2req_valid), PW'(0));
        check("areset_packet", bus.l2req_packet, PW'(0));
        check("areset_stall", PW'(pc_event_l2_stall), PW'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        drive(3'b111, 1'b1);
        check("areset_restart_ready", PW'(bus.req_ready), PW'(3'b001));
        tick();
        drive(3'b000, 1'b1);
        check("areset_restart_unit", PW'(bus.l2req_unit), PW'(0));
        tick();

        // Randomized run against the reference model
        do_reset();
        m_valid = 0;
        m_pkt   = '0;
        m_unit  = 0;
        m_ptr   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_cnt[i]    = 0;
            pend[i]     = 0;
            pend_pkt[i] = '0;
        end
        begin
            int stall_left = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                logic [NUM_REQ-1:0] rv;
                logic [NUM_REQ-1:0] e_ready;
                logic [NUM_REQ-1:0] e_starved;
                logic l2r;
                bit load;
                int win;

                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i] && $urandom_range(2, 0) == 0) begin
                        pend[i]     = 1;
                        pend_pkt[i] = {$urandom, $urandom, $urandom, $urandom};
                    end
                    rv[i] = pend[i];
                    set_pkt(i, pend_pkt[i]);
                end
                if (stall_left == 0 && $urandom_range(39, 0) == 0) stall_left = 18;
                if (stall_left > 0) begin
                    l2r = 1'b0;
                    stall_left--;
                end else begin
                    l2r = ($urandom_range(3, 0) != 0);
                end

                load = !m_valid || l2r;
                win  = -1;
                if (load) begin
                    for (int o = 0; o < NUM_REQ; o++) begin
                        int id;
                        id = (m_ptr + o) % NUM_REQ;
                        if (win < 0 && pend[id]) win = id;
                    end
                end
                e_ready = '0;
                if (win >= 0) e_ready[win] = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) e_starved[i] = (m_cnt[i] == LIMIT);

                drive(rv, l2r);
                check("rnd_ready", PW'(bus.req_ready), PW'(e_ready));
                check("rnd_valid", PW'(bus.l2req_valid), PW'(m_valid));
                check("rnd_stall", PW'(pc_event_l2_stall), PW'(m_valid && !l2r));
                check("rnd_starved", PW'(pc_event_starved), PW'(e_starved));
                if (m_valid) begin
                    check("rnd_packet", bus.l2req_packet, m_pkt);
                    check("rnd_unit", PW'(bus.l2req_unit), PW'(m_unit));
                end

                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i] || win == i) m_cnt[i] = 0;
                    else if (m_cnt[i] < LIMIT) m_cnt[i]++;
                end
                if (win >= 0) begin
                    m_valid   = 1;
                    m_pkt     = pend_pkt[win];
                    m_unit    = win;
                    m_ptr     = (win + 1) % NUM_REQ;
                    pend[win] = 0;
                end else if (load) begin
                    m_valid = 0;
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
